addsub_seq8: RTL and testbench

Byte-serial multi-byte add/subtract sequencer that reuses a single 8-bit ripple adder across NBYTES cycles, chaining carry through a register. It sits between a requester issuing wide operands with a start/done handshake and the team's existing 8-bit adder datapath. It trades NBYTES+1 cycles of latency for one adder instance.

---
 rtl/addsub_seq_pkg.sv | 23 ++
 rtl/adder8.sv | 12 +
 rtl/addsub_seq8.sv | 126 ++++++++++++
 tb/tb_addsub_seq8.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/addsub_seq_pkg.sv
// Shared definitions for the byte-serial add/subtract sequencer.
// State encodings and an index-width helper.
package addsub_seq_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    StIdle = S_IDLE,
    StRun  = S_RUN,
    StDone = S_DONE
  } state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w = 0;
    for (int unsigned v = n - 1; v > 0; v = v >> 1) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/adder8.sv
// Existing 8-bit adder datapath: S = A + B + C0, carry out on C8.
module adder8 (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       C0,
  output logic [7:0] S,
  output logic       C8
);

  assign {C8, S} = {1'b0, A} + {1'b0, B} + {8'd0, C0};

endmodule

// File: rtl/addsub_seq8.sv
// Multi-byte add/subtract that walks one 8-bit adder across NBYTES cycles,
// chaining the carry through a register.
module addsub_seq8
  import addsub_seq_pkg::*;
#(
  parameter int unsigned NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  sub,
  input  logic                  cin,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   sum,
  output logic                  cout,
  output logic                  ovf
);

  localparam int unsigned W    = 8 * NBYTES;
  localparam int unsigned IdxW = clog2(NBYTES);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NBYTES - 1);

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic            sub_q, sub_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, work_q, work_d, sum_q, sum_d;
  logic            cout_q, cout_d, ovf_q, ovf_d;

  logic [7:0] a_byte, b_byte, b_eff, s_byte;
  logic       c_out;
  logic       accept;

  assign a_byte = a_q[{idx_q, 3'b000} +: 8];
  assign b_byte = b_q[{idx_q, 3'b000} +: 8];
  assign b_eff  = sub_q ? ~b_byte : b_byte;

  adder8 u_adder8 (
    .A  (a_byte),
    .B  (b_eff),
    .C0 (carry_q),
    .S  (s_byte),
    .C8 (c_out)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    a_d     = a_q;
    b_d     = b_q;
    work_d  = work_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    accept  = 1'b0;

    unique case (state_q)
      StIdle: accept = start;
      StRun: begin
        work_d[{idx_q, 3'b000} +: 8] = s_byte;
        carry_d = c_out;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          // Results publish on the edge into DONE so they are valid with the pulse.
          state_d = StDone;
          idx_d   = '0;
          sum_d   = work_d;
          cout_d  = c_out;
          ovf_d   = (a_byte[7] == b_eff[7]) && (s_byte[7] != a_byte[7]);
        end
      end
      StDone: begin
        state_d = StIdle;
        accept  = start;
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      state_d = StRun;
      a_d     = a;
      b_d     = b;
      sub_d   = sub;
      carry_d = sub | cin;
      idx_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      a_q     <= a_d;
      b_q     <= b_d;
      work_q  <= work_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_addsub_seq8.sv
// Directed bench for addsub_seq8 with NBYTES=4 and hand-computed results.
module tb_addsub_seq8;

  localparam int unsigned NBYTES = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, sub, cin;
  logic [31:0] a, b;
  logic        busy, done, cout, ovf;
  logic [31:0] sum;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] last_sum = '0;

  always #5 clk = ~clk;

  addsub_seq8 #(.NBYTES(NBYTES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .cin   (cin),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an operation and let the next edge accept it.
  task automatic launch(input logic [31:0] av, input logic [31:0] bv, input logic s,
                        input logic c);
    a     = av;
    b     = bv;
    sub   = s;
    cin   = c;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Called in cycle T+1; returns in the done cycle T+NBYTES+1.
  task automatic expect_result(input string tag, input logic [31:0] es, input logic ec,
                               input logic eo, input bit hold);
    for (int i = 1; i <= NBYTES; i++) begin
      check({tag, " busy"}, 64'(busy), 64'd1);
      check({tag, " done_low"}, 64'(done), 64'd0);
      check({tag, " sum_held"}, 64'(sum), 64'(last_sum));
      if (hold) begin
        start = 1'b1;
        a     = $urandom;
        b     = $urandom;
        sub   = 1'($urandom_range(0, 1));
        cin   = 1'b1;
      end
      step();
    end
    if (hold) begin
      start = 1'b0;
      a     = '0;
      b     = '0;
    end
    check({tag, " done"}, 64'(done), 64'd1);
    check({tag, " busy_low"}, 64'(busy), 64'd0);
    check({tag, " sum"}, 64'(sum), 64'(es));
    check({tag, " cout"}, 64'(cout), 64'(ec));
    check({tag, " ovf"}, 64'(ovf), 64'(eo));
    last_sum = es;
  endtask

  task automatic idle_check(input string tag);
    step();
    check({tag, " idle_busy"}, 64'(busy), 64'd0);
    check({tag, " idle_done"}, 64'(done), 64'd0);
    check({tag, " idle_sum"}, 64'(sum), 64'(last_sum));
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    cin   = 1'b0;
    a     = '0;
    b     = '0;
    #3;
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst sum", 64'(sum), 64'd0);
    check("rst cout", 64'(cout), 64'd0);
    check("rst ovf", 64'(ovf), 64'd0);
    #9 rst_n = 1'b1;
    step();
    step();

    launch(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    expect_result("add_carry", 32'h0000_0100, 1'b0, 1'b0, 1'b0);
    idle_check("add_carry");

    launch(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    expect_result("wrap_b1", 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    idle_check("wrap_b1");

    launch(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1);
    expect_result("wrap_cin", 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    idle_check("wrap_cin");

    launch(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    expect_result("ovf_add", 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    idle_check("ovf_add");

    launch(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0);
    expect_result("ovf_sub", 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    idle_check("ovf_sub");

    launch(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1);
    expect_result("borrow_cin1", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    idle_check("borrow_cin1");

    launch(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0);
    expect_result("borrow_cin0", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    idle_check("borrow_cin0");

    // start held and operands scrambled during RUN.
    launch(32'h0102_0304, 32'h1020_3040, 1'b0, 1'b0);
    expect_result("hold", 32'h1122_3344, 1'b0, 1'b0, 1'b1);

    // Accepted in the DONE cycle for back-to-back operation.
    launch(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0);
    expect_result("b2b", 32'h0000_0003, 1'b0, 1'b0, 1'b0);
    idle_check("b2b");

    launch(32'hA5A5_A5A5, 32'h0000_0001, 1'b0, 1'b0);
    step();
    rst_n = 1'b0;
    #1;
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    check("abort sum", 64'(sum), 64'd0);
    check("abort cout", 64'(cout), 64'd0);
    check("abort ovf", 64'(ovf), 64'd0);
    last_sum = '0;
    step();
    step();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("abort no_done", 64'(done), 64'd0);
      check("abort no_busy", 64'(busy), 64'd0);
    end

    launch(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    expect_result("post_reset", 32'h2345_6789, 1'b0, 1'b0, 1'b0);
    idle_check("post_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
